// File: rtl/player_pkg.sv
// Shared definitions for the playback timer controller: state encoding,
// datapath widths and small helpers.
package player_pkg;

    localparam int TIME_W        = 10;
    localparam int ADDER_W       = 9;
    localparam int MAX_TRACK_SEC = 599;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_FF    = 3'd3,
        ST_RW    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // States in which the Timer is being stepped and the tick counter runs.
    function automatic logic is_running(state_t s);
        return (s == ST_PLAY) || (s == ST_FF) || (s == ST_RW);
    endfunction

endpackage

// File: rtl/bcd_time_to_sec.sv
// Converts the Timer's BCD digits (m:ss, single minute digit) into a plain
// binary seconds count. Purely combinational.
module bcd_time_to_sec
    import player_pkg::*;
(
    input  logic [3:0]        minutes0,
    input  logic [3:0]        seconds1,
    input  logic [3:0]        seconds0,
    output logic [TIME_W-1:0] seconds
);

    // Largest legal input 9:59 = 599 fits comfortably in TIME_W bits.
    assign seconds = TIME_W'(minutes0) * TIME_W'(60)
                   + TIME_W'(seconds1) * TIME_W'(10)
                   + TIME_W'(seconds0);

endmodule

// File: rtl/playback_timer_ctrl.sv
// Sequencing controller for the elapsed-time Timer: turns button pulses into
// count/adder/clear commands, clamps at 0:00 and at the track length, and
// flags end of track. The Timer's BCD outputs are fed back as elapsed time.
module playback_timer_ctrl
    import player_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int FF_STEP  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_play,
    input  logic               btn_ff,
    input  logic               btn_rw,
    input  logic               btn_stop,
    input  logic [TIME_W-1:0]  track_len,
    input  logic [3:0]         seconds0,
    input  logic [3:0]         seconds1,
    input  logic [3:0]         minutes0,
    output logic               timer_count,
    output logic [ADDER_W-1:0] timer_adder,
    output logic               timer_clr,
    output logic               done,
    output logic [2:0]         state
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0]  FF_STEP_T = TIME_W'(FF_STEP);
    localparam logic [ADDER_W-1:0] ADD_ONE   = ADDER_W'(1);
    localparam logic [ADDER_W-1:0] ADD_FF    = ADDER_W'(FF_STEP);

    state_t              cur_state, nxt_state;
    logic [TICK_W-1:0]   tick, tick_nxt;
    logic                count_nxt, clr_nxt, done_nxt;
    logic [ADDER_W-1:0]  adder_nxt;
    logic [TIME_W-1:0]   elapsed, remaining;
    logic                step_due;

    bcd_time_to_sec u_elapsed (
        .minutes0 (minutes0),
        .seconds1 (seconds1),
        .seconds0 (seconds0),
        .seconds  (elapsed)
    );

    assign remaining = (track_len > elapsed) ? (track_len - elapsed) : '0;
    assign step_due  = is_running(cur_state) && (tick == TICK_LAST);
    assign state     = cur_state;

    // Next state and next registered outputs: buttons by priority, else a step.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        nxt_state = cur_state;
        count_nxt = 1'b0;
        adder_nxt = timer_adder;
        clr_nxt   = 1'b0;
        done_nxt  = 1'b0;

        if (btn_stop) begin
            nxt_state = ST_IDLE;
            clr_nxt   = 1'b1;
        end else if (btn_play) begin
            case (cur_state)
                ST_IDLE, ST_PAUSE: nxt_state = ST_PLAY;
                ST_DONE: begin
                    nxt_state = ST_PLAY;
                    clr_nxt   = 1'b1;
                end
                default: nxt_state = ST_PAUSE;
            endcase
        end else if (btn_ff && (cur_state inside {ST_PLAY, ST_PAUSE, ST_FF, ST_RW})) begin
            nxt_state = (cur_state == ST_FF) ? ST_PLAY : ST_FF;
        end else if (btn_rw && (cur_state inside {ST_PLAY, ST_PAUSE, ST_FF, ST_RW})) begin
            nxt_state = (cur_state == ST_RW) ? ST_PLAY : ST_RW;
        end else if (step_due) begin
            case (cur_state)
                ST_PLAY: begin
                    if (remaining != '0) begin
                        count_nxt = 1'b1;
                        adder_nxt = ADD_ONE;
                    end
                    if (remaining <= TIME_W'(1)) begin
                        nxt_state = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
                ST_FF: begin
                    if (remaining > FF_STEP_T) begin
                        count_nxt = 1'b1;
                        adder_nxt = ADD_FF;
                    end else begin
                        // Final partial step lands exactly on the track length.
                        count_nxt = (remaining != '0);
                        if (remaining != '0) adder_nxt = ADDER_W'(remaining);
                        nxt_state = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
                ST_RW: begin
                    if (elapsed > FF_STEP_T) begin
                        count_nxt = 1'b1;
                        adder_nxt = ADDER_W'(0) - ADD_FF;
                    end else begin
                        // Final partial step lands exactly on 0:00.
                        count_nxt = (elapsed != '0);
                        if (elapsed != '0) adder_nxt = ADDER_W'(0) - ADDER_W'(elapsed);
                        nxt_state = ST_PAUSE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tick divider: runs only while stepping, restarts on every state change.
    always_comb begin
        tick_nxt = '0;
        if (is_running(cur_state) && (nxt_state == cur_state) && (tick != TICK_LAST))
            tick_nxt = tick + TICK_W'(1);
    end

    // State and output registers; reset holds the Timer cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state   <= ST_IDLE;
            tick        <= '0;
            timer_count <= 1'b0;
            timer_adder <= ADD_ONE;
            timer_clr   <= 1'b1;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            cur_state   <= nxt_state;
            tick        <= tick_nxt;
            timer_count <= count_nxt;
            timer_adder <= adder_nxt;
            timer_clr   <= clr_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_playback_timer_ctrl.sv
// Closed-loop bench: a behavioural Timer model consumes the controller's
// commands and feeds its BCD digits back.
module tb_playback_timer_ctrl;
    import player_pkg::*;

    logic        clk;
    logic        reset;
    logic        btn_play, btn_ff, btn_rw, btn_stop;
    logic [9:0]  track_len;
    logic [3:0]  seconds0, seconds1, minutes0;
    logic        timer_count;
    logic [8:0]  timer_adder;
    logic        timer_clr;
    logic        done;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    playback_timer_ctrl #(.TICK_DIV(4), .FF_STEP(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_play    (btn_play),
        .btn_ff      (btn_ff),
        .btn_rw      (btn_rw),
        .btn_stop    (btn_stop),
        .track_len   (track_len),
        .seconds0    (seconds0),
        .seconds1    (seconds1),
        .minutes0    (minutes0),
        .timer_count (timer_count),
        .timer_adder (timer_adder),
        .timer_clr   (timer_clr),
        .done        (done),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Timer model: clear has priority, otherwise apply the signed step.
    int timer_sec = 0;
    always @(posedge clk) begin
        if (timer_clr)        timer_sec <= 0;
        else if (timer_count) timer_sec <= timer_sec + int'($signed(timer_adder));
    end
    assign minutes0 = 4'(timer_sec / 60);
    assign seconds1 = 4'((timer_sec % 60) / 10);
    assign seconds0 = 4'(timer_sec % 10);

    // Monitor: log every count pulse (cycle and adder) and every done pulse.
    int         cyc = 0;
    int         pulse_cyc[$];
    logic [8:0] pulse_add[$];
    int         done_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (timer_count) begin
            pulse_cyc.push_back(cyc);
            pulse_add.push_back(timer_adder);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_add.delete();
        done_cnt = 0;
    endtask

    task automatic press(input logic p, input logic f, input logic r, input logic s);
        btn_play = p; btn_ff = f; btn_rw = r; btn_stop = s;
        @(negedge clk);
        btn_play = 1'b0; btn_ff = 1'b0; btn_rw = 1'b0; btn_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_sec(input string name, input int target, input int budget);
        for (int i = 0; i < budget && timer_sec != target; i++) @(negedge clk);
        check(name, timer_sec, target);
    endtask

    task automatic wait_state(input string name, input logic [2:0] target, input int budget);
        for (int i = 0; i < budget && state != target; i++) @(negedge clk);
        check(name, int'(state), int'(target));
    endtask

    function automatic int bad_gaps();
        int bad = 0;
        for (int i = 1; i < pulse_cyc.size(); i++)
            if (pulse_cyc[i] - pulse_cyc[i-1] != 4) bad++;
        return bad;
    endfunction

    typedef struct {
        logic       play, ff, rw, stop;
        logic [2:0] exp_state;
        logic       exp_clr;
    } vec_t;
    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,  1'b0}; // ff ignored in IDLE
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,  1'b0}; // rw ignored in IDLE
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PLAY,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PAUSE, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_FF,    1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_PLAY,  1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_RW,    1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_PLAY,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, ST_FF,    1'b0}; // ff beats rw
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_RW,    1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PAUSE, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_RW,    1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_FF,    1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PAUSE, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_PLAY,  1'b0}; // play beats ff
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE,  1'b1}; // stop beats play
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,  1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PLAY,  1'b0};

        reset = 1'b0;
        btn_play = 1'b0; btn_ff = 1'b0; btn_rw = 1'b0; btn_stop = 1'b0;
        track_len = 10'd599;

        // Reset values, then timer_clr holds until the first edge after release.
        idle(3);
        check("rst state", int'(state), ST_IDLE);
        check("rst clr", int'(timer_clr), 1);
        check("rst count", int'(timer_count), 0);
        check("rst adder", int'(timer_adder), 1);
        check("rst done", int'(done), 0);
        reset = 1'b1;
        #1;
        check("clr before first edge", int'(timer_clr), 1);
        @(negedge clk);
        check("clr after first edge", int'(timer_clr), 0);
        check("state after release", int'(state), ST_IDLE);

        // Button transition table, one button cycle per entry.
        for (int i = 0; i < 18; i++) begin
            press(vecs[i].play, vecs[i].ff, vecs[i].rw, vecs[i].stop);
            check($sformatf("vec%0d state", i), int'(state), int'(vecs[i].exp_state));
            check($sformatf("vec%0d clr", i), int'(timer_clr), int'(vecs[i].exp_clr));
        end
        check("table timer", timer_sec, 0);

        // Play a 70 s track to completion.
        press(1'b0, 1'b0, 1'b0, 1'b1);
        track_len = 10'd70;
        idle(1);
        clear_log();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_state("play reaches DONE", ST_DONE, 400);
        idle(20);
        check("play pulses", pulse_add.size(), 70);
        check("play adders +1", int'(pulse_add.sum() with (int'(item))), 70);
        check("play gaps", bad_gaps(), 0);
        check("play timer", timer_sec, 70);
        check("play done pulses", done_cnt, 1);
        check("play stays DONE", int'(state), ST_DONE);

        // Restart from DONE, then FF entered exactly on a step cycle at 0:05.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart clr", int'(timer_clr), 1);
        check("restart state", int'(state), ST_PLAY);
        @(negedge clk);
        check("restart clr drop", int'(timer_clr), 0);
        for (int i = 0; i < 100 && !(timer_count && timer_sec == 4); i++) @(negedge clk);
        check("step to 0:05 seen", int'(timer_count), 1);
        idle(3);
        check("at 0:05", timer_sec, 5);
        clear_log();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check("collision state FF", int'(state), ST_FF);
        check("collision step skipped", int'(timer_count), 0);
        wait_state("ff reaches DONE", ST_DONE, 100);
        idle(20);
        check("ff pulses", pulse_add.size(), 9);
        for (int i = 0; i < pulse_add.size(); i++)
            check($sformatf("ff adder%0d", i), int'(pulse_add[i]), (i < 8) ? 8 : 1);
        check("ff gaps", bad_gaps(), 0);
        check("ff timer", timer_sec, 70);
        check("ff done pulses", done_cnt, 1);

        // Rewind from 0:13 down to 0:00 then PAUSE.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_sec("reach 0:13", 13, 200);
        clear_log();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        wait_state("rw reaches PAUSE", ST_PAUSE, 100);
        idle(20);
        check("rw pulses", pulse_add.size(), 2);
        if (pulse_add.size() == 2) begin
            check("rw adder -8", int'(pulse_add[0]), 'h1F8);
            check("rw adder -5", int'(pulse_add[1]), 'h1FB);
        end
        check("rw timer", timer_sec, 0);
        check("rw done none", done_cnt, 0);
        check("rw stays PAUSE", int'(state), ST_PAUSE);

        // Rewind at 0:00: straight back to PAUSE with no count.
        clear_log();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("rw0 state RW", int'(state), ST_RW);
        wait_state("rw0 back to PAUSE", ST_PAUSE, 20);
        idle(5);
        check("rw0 pulses", pulse_add.size(), 0);

        // Stop and play together while playing at 0:30.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_sec("reach 0:30", 30, 200);
        clear_log();
        press(1'b1, 1'b0, 1'b0, 1'b1);
        check("stop+play state", int'(state), ST_IDLE);
        check("stop+play clr", int'(timer_clr), 1);
        @(negedge clk);
        check("stop+play clr drop", int'(timer_clr), 0);
        idle(10);
        check("stop+play timer", timer_sec, 0);
        check("stop+play idle", int'(state), ST_IDLE);
        check("stop+play pulses", pulse_add.size(), 0);

        // Track length shortened below elapsed mid-play.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_sec("reach 0:10", 10, 100);
        track_len = 10'd5;
        clear_log();
        wait_state("short track DONE", ST_DONE, 20);
        idle(5);
        check("short track pulses", pulse_add.size(), 0);
        check("short track timer", timer_sec, 10);
        check("short track done", done_cnt, 1);

        // Zero-length track.
        press(1'b0, 1'b0, 1'b0, 1'b1);
        track_len = 10'd0;
        clear_log();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_state("zero track DONE", ST_DONE, 20);
        idle(5);
        check("zero track pulses", pulse_add.size(), 0);
        check("zero track done", done_cnt, 1);

        // Asynchronous reset in the middle of fast-forward.
        press(1'b0, 1'b0, 1'b0, 1'b1);
        track_len = 10'd599;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !timer_count; i++) @(negedge clk);
        check("ff pulse before reset", int'(timer_count), 1);
        check("ff adder before reset", int'(timer_adder), 8);
        #2 reset = 1'b0;
        #1;
        check("async rst state", int'(state), ST_IDLE);
        check("async rst count", int'(timer_count), 0);
        check("async rst adder", int'(timer_adder), 1);
        check("async rst clr", int'(timer_clr), 1);
        check("async rst done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        check("after reset state", int'(state), ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/playback_timer_ctrl.md
Name: playback_timer_ctrl

Overview:
- Sequencing controller for the player's elapsed-time Timer.
- Turns one-cycle user button pulses (play/pause, fast-forward, rewind, stop) into the Timer's `count` enable, signed `adder` step and clear.
- Clamps the time at 0:00 and at the track length, and flags end of track.
- Sits between the button debouncers and the Timer. The Timer's BCD outputs feed back into this block.

Parameters:
- TICK_DIV, 4: clk cycles per Timer step while running; must be ≥2 so the Timer feedback is settled before the next step.
- FF_STEP, 8: seconds per step in FF/RW; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_play  in  1  one-cycle pulse: play/pause toggle
- btn_ff  in  1  one-cycle pulse: fast-forward toggle
- btn_rw  in  1  one-cycle pulse: rewind toggle
- btn_stop  in  1  one-cycle pulse: stop and clear
- track_len  in  10  track length in seconds, 0..599
- seconds0  in  4  Timer BCD seconds units
- seconds1  in  4  Timer BCD seconds tens
- minutes0  in  4  Timer BCD minutes
- timer_count  out  1  Timer count enable, one-cycle pulse per step
- timer_adder  out  9  signed step applied with timer_count
- timer_clr  out  1  active-high Timer reset
- done  out  1  one-cycle pulse on reaching end of track
- state  out  3  current FSM state, for status LEDs

Behaviour:
- Reset values while reset=0:
  - state=IDLE
  - timer_count=0
  - timer_adder=+1
  - timer_clr=1; it deasserts on the first clk edge after reset releases
  - done=0
  - tick counter=0
- States and encodings: IDLE=0, PLAY=1, PAUSE=2, FF=3, RW=4, DONE=5.
- Elapsed time: elapsed = minutes0*60 + seconds1*10 + seconds0, computed combinationally as 10 bits unsigned. remaining = track_len − elapsed, saturating at 0.
- Button priority within one cycle: stop > play > ff > rw. Lower-priority buttons in the same cycle are ignored.
- btn_stop, from any state: go to IDLE and pulse timer_clr=1 for exactly 1 cycle.
- btn_play:
  - IDLE/PAUSE → PLAY
  - PLAY/FF/RW → PAUSE
  - DONE → PLAY, with a 1-cycle timer_clr (restart)
- btn_ff:
  - PLAY/PAUSE/RW → FF
  - FF → PLAY
  - ignored in IDLE/DONE
- btn_rw:
  - PLAY/PAUSE/FF → RW
  - RW → PLAY
  - ignored in IDLE/DONE
- Tick counter:
  - Free-runs 0..TICK_DIV−1 only in PLAY/FF/RW.
  - Cleared to 0 on any state change and in all other states.
- Step cycle: when tick counter = TICK_DIV−1 (and no button is taken that cycle), the registered outputs change at the next edge:
  - PLAY: step=+1.
    - remaining > 1: timer_count=1, adder=+1.
    - remaining = 1: count with adder=+1, then → DONE.
    - remaining = 0: no count, → DONE.
  - FF:
    - remaining > FF_STEP: count with adder=+FF_STEP.
    - 0 < remaining ≤ FF_STEP: count with adder=+remaining, then → DONE.
    - remaining = 0: no count, → DONE.
  - RW:
    - elapsed > FF_STEP: count with adder=−FF_STEP.
    - 0 < elapsed ≤ FF_STEP: count with adder=−elapsed, then → PAUSE.
    - elapsed = 0: no count, → PAUSE.
- timer_count is high for exactly 1 cycle per step. timer_adder holds its last value between steps.
- Entering DONE raises done for 1 cycle. Timer is frozen in DONE.
- track_len=0 in PLAY/FF: the first step cycle goes to DONE with no count.
- A track_len change mid-play takes effect at the next step cycle. If track_len < elapsed, remaining saturates to 0 and the FSM goes to DONE.
- Button and step cycle in the same cycle: the button wins and the step is skipped.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously).

Decomposition:
- Shared package `player_pkg`:
  - state encoding constants
  - width constants: TIME_W=10, ADDER_W=9
  - MAX_TRACK_SEC=599
- One natural sub-module, `bcd_time_to_sec`: combinational conversion of (minutes0, seconds1, seconds0) to 10-bit seconds, instantiated once and reusable by the track-length display.

Test Plan (TICK_DIV=4, FF_STEP=8; bench instantiates the Timer in closed loop):
- Reset release → timer_clr=1 until the first edge, then 0; state=IDLE, timer_count=0, adder=+1.
- track_len=70, btn_play → timer_count every 4 cycles with adder=+1. After 70 steps the Timer reads 1:10, done pulses once, state=DONE, no further counts.
- At 0:05 PLAY, btn_ff → adders +8 ×8 reach 1:09; the next step uses adder=+1, Timer shows 1:10, then DONE.
- At 0:13, btn_rw → steps −8 to 0:05, then adder=−5 to 0:00, then state=PAUSE with no further counts.
- btn_stop and btn_play in the same cycle while in PLAY at 0:30 → state=IDLE, one-cycle timer_clr, Timer 0:00, play ignored.
- In DONE, btn_play → 1-cycle timer_clr, state=PLAY, counting resumes from 0:00. Reset pulsed mid-FF → outputs return to reset values immediately.
